// File: rtl/tx_link_ctrl.sv
// ---------------------------------------------------------------------------
// tx_link_ctrl : JESD204B transmit link-layer sequencer.
// Steps the lanes through CGS (K28.5), ILAS and user data, based on the LMFC
// multiframe-end flag, LMFC SYNCED status and the receiver SYNC~ request.
// It also detects SYNC~ error-report pulses and keeps a saturating count.
//
// Optional build macro: TX_LINK_ILAS_BYPASS_EN adds ILAS_BYPASS. When that
// input is high, CGS exits straight to DATA and no ILAS is sent.
//
// Ports:
//   CLK          link clock
//   RST_n        synchronous active-low reset
//   EN           link enable (low forces IDLE)
//   SUBCLASSV    0 = subclass 0, nonzero = subclass 1
//   SYNCED       LMFC aligned to SYSREF
//   ME_LAST      last cycle of an LMFC multiframe
//   SYNC_n       receiver SYNC~ (asynchronous, active-low)
//   ILAS_BYPASS  skip ILAS (only with TX_LINK_ILAS_BYPASS_EN)
//   STATE        0 IDLE, 1 CGS, 2 ILAS, 3 DATA
//   CGS_EN       transmit K28.5
//   ILAS_EN      transmit ILAS sequence
//   ILAS_MF      current ILAS multiframe index
//   ILAS_CFG     ILAS link-configuration multiframe (index 1)
//   DATA_EN      transmit user data
//   ERR_PULSE    one-cycle pulse per detected SYNC~ error report
//   ERR_CNT      saturating error-report count
// ---------------------------------------------------------------------------
module tx_link_ctrl #(
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned ILAS_MF_NUM   = 4,
  parameter int unsigned RESYNC_CYCLES = 32
) (
  input  logic       CLK,
  input  logic       RST_n,
  input  logic       EN,
  input  logic [2:0] SUBCLASSV,
  input  logic       SYNCED,
  input  logic       ME_LAST,
  input  logic       SYNC_n,
`ifdef TX_LINK_ILAS_BYPASS_EN
  input  logic       ILAS_BYPASS,
`endif
  output logic [1:0] STATE,
  output logic       CGS_EN,
  output logic       ILAS_EN,
  output logic [1:0] ILAS_MF,
  output logic       ILAS_CFG,
  output logic       DATA_EN,
  output logic       ERR_PULSE,
  output logic [7:0] ERR_CNT
);

  localparam int unsigned CNT_W = 8;
  localparam int unsigned MF_W  = 2;
  localparam logic [CNT_W-1:0] RESYNC_MAX = CNT_W'(RESYNC_CYCLES);
  localparam logic [MF_W-1:0]  MF_LAST    = MF_W'(ILAS_MF_NUM - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CGS  = 2'd1,
    ST_ILAS = 2'd2,
    ST_DATA = 2'd3
  } state_t;

  state_t                 r_state;
  logic [SYNC_STAGES-1:0] r_sync;
  logic [CNT_W-1:0]       r_low_cnt;
  logic [MF_W-1:0]        r_ilas_mf;
  logic                   r_cgs_en;
  logic                   r_ilas_en;
  logic                   r_ilas_cfg;
  logic                   r_data_en;
  logic                   r_err_pulse;
  logic [CNT_W-1:0]       r_err_cnt;

  state_t                 w_state_nxt;
  logic                   w_sync_s;
  logic                   w_sc1;
  logic                   w_bypass;
  logic                   w_in_link;
  logic                   w_nxt_link;
  logic [CNT_W-1:0]       w_low_inc;
  logic [CNT_W-1:0]       w_low_nxt;
  logic [MF_W-1:0]        w_ilas_mf_nxt;
  logic                   w_resync;
  logic                   w_err;
  logic                   w_los;
  logic                   w_cgs_exit;
  logic                   w_ilas_last;

`ifdef TX_LINK_ILAS_BYPASS_EN
  assign w_bypass = ILAS_BYPASS;
`else
  assign w_bypass = 1'b0;
`endif

  assign w_sync_s  = r_sync[SYNC_STAGES-1];
  assign w_sc1     = |SUBCLASSV;
  assign w_in_link = (r_state == ST_ILAS) || (r_state == ST_DATA);

  // Saturating increment of the consecutive-low run of sync_s
  assign w_low_inc = (r_low_cnt >= RESYNC_MAX) ? RESYNC_MAX : r_low_cnt + CNT_W'(1);

  // The cycle that completes RESYNC_CYCLES low samples requests resync
  assign w_resync = w_in_link && !w_sync_s && (w_low_inc == RESYNC_MAX);

  // A short low run ending (sync_s back high) is an error report
  assign w_err = EN && w_in_link && w_sync_s &&
                 (r_low_cnt != '0) && (r_low_cnt < RESYNC_MAX);

  assign w_los       = w_in_link && w_sc1 && !SYNCED;
  assign w_cgs_exit  = (r_state == ST_CGS) && ME_LAST && w_sync_s && (!w_sc1 || SYNCED);
  assign w_ilas_last = (r_state == ST_ILAS) && ME_LAST && (r_ilas_mf == MF_LAST);

  // Next state in priority order: EN, loss of alignment, resync, normal flow
  assign w_state_nxt = !EN                  ? ST_IDLE :
                       (r_state == ST_IDLE) ? ST_CGS  :
                       w_los                ? ST_CGS  :
                       w_resync             ? ST_CGS  :
                       w_cgs_exit           ? (w_bypass ? ST_DATA : ST_ILAS) :
                       w_ilas_last          ? ST_DATA :
                       r_state;

  assign w_nxt_link = (w_state_nxt == ST_ILAS) || (w_state_nxt == ST_DATA);

  // Low run keeps counting across ILAS->DATA; cleared on any exit from the link
  assign w_low_nxt = (w_in_link && w_nxt_link && !w_sync_s) ? w_low_inc : '0;

  // ILAS index advances per multiframe while staying in ILAS, else clears
  assign w_ilas_mf_nxt = ((r_state == ST_ILAS) && (w_state_nxt == ST_ILAS)) ?
                         (ME_LAST ? r_ilas_mf + MF_W'(1) : r_ilas_mf) : '0;

  // State, synchronizer, counters and registered outputs
  always_ff @(posedge CLK) begin
    if (!RST_n) begin
      r_state     <= ST_IDLE;
      r_sync      <= '1;
      r_low_cnt   <= '0;
      r_ilas_mf   <= '0;
      r_cgs_en    <= 1'b0;
      r_ilas_en   <= 1'b0;
      r_ilas_cfg  <= 1'b0;
      r_data_en   <= 1'b0;
      r_err_pulse <= 1'b0;
      r_err_cnt   <= '0;
    end else begin
      r_sync      <= {r_sync[SYNC_STAGES-2:0], SYNC_n};
      r_state     <= w_state_nxt;
      r_low_cnt   <= w_low_nxt;
      r_ilas_mf   <= w_ilas_mf_nxt;
      r_cgs_en    <= (w_state_nxt == ST_CGS);
      r_ilas_en   <= (w_state_nxt == ST_ILAS);
      r_ilas_cfg  <= (w_state_nxt == ST_ILAS) && (w_ilas_mf_nxt == MF_W'(1));
      r_data_en   <= (w_state_nxt == ST_DATA);
      r_err_pulse <= w_err;
      if (w_err && (r_err_cnt != '1)) begin
        r_err_cnt <= r_err_cnt + CNT_W'(1);
      end
    end
  end

  assign STATE     = r_state;
  assign CGS_EN    = r_cgs_en;
  assign ILAS_EN   = r_ilas_en;
  assign ILAS_MF   = r_ilas_mf;
  assign ILAS_CFG  = r_ilas_cfg;
  assign DATA_EN   = r_data_en;
  assign ERR_PULSE = r_err_pulse;
  assign ERR_CNT   = r_err_cnt;

endmodule
